// File: rtl/data_sampling_mv.sv
// Majority-vote bit sampler for the UART receiver oversampling front end.
// Collects a window of 1, 3 or 5 samples centred on prescale/2 and, once the
// window closes, presents the voted bit with a one-cycle valid strobe. Bits
// whose samples disagree and configurations that shrink the vote are flagged.
module data_sampling_mv #(
  parameter int PRESCALE_W = 6,
  parameter int EDGE_W     = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  data_sample_en,
  input  logic                  RX_IN,
  input  logic [EDGE_W-1:0]     edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  sample_mode,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_err,
  output logic                  cfg_err
);

  // Common width so edge positions and window bounds compare without truncation.
  localparam int CW = (PRESCALE_W > EDGE_W) ? PRESCALE_W : EDGE_W;

  // Configuration snapshot, frozen while a frame is being sampled.
  logic [PRESCALE_W-1:0] cfg_prescale_q;
  logic                  cfg_mode_q;

  // Per-bit accumulators (saturating, so a runaway window can never wrap).
  logic [2:0] ones_q;
  logic [2:0] cnt_q;

  // Window geometry derived from the configuration snapshot.
  logic [1:0]    half_k;
  logic [2:0]    n_samples;
  logic [CW-1:0] mid_w;
  logic [CW-1:0] lo_w;
  logic [CW-1:0] hi_w;
  logic [CW-1:0] edge_w;
  logic [CW-1:0] pre_w;

  // Per-cycle decode of the current edge position.
  logic       edge_ok;
  logic       new_bit;
  logic       in_win;
  logic       decide;
  logic [2:0] base_ones;
  logic [2:0] base_cnt;
  logic [2:0] ones_d;
  logic [2:0] cnt_d;
  logic       cfg_err_d;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Choose the half-width of the vote window the configuration can support.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    half_k = 2'd1;
    if (cfg_prescale_q < 4) begin
      half_k = 2'd0;
    end else if (cfg_mode_q && (cfg_prescale_q >= 8)) begin
      half_k = 2'd2;
    end
  end

  // Window bounds: mid-K .. mid+K, with N = 2K+1 samples expected.
  always_comb begin
    n_samples = {half_k, 1'b1};
    mid_w     = CW'(cfg_prescale_q >> 1);
    lo_w      = mid_w - CW'(half_k);
    hi_w      = mid_w + CW'(half_k);
    edge_w    = CW'(edge_cnt);
    pre_w     = CW'(cfg_prescale_q);
  end

  // Fold the current sample into the running counts and detect window close.
  always_comb begin
    edge_ok   = edge_w < pre_w;
    new_bit   = edge_ok && (edge_w == '0);
    in_win    = edge_ok && (edge_w >= lo_w) && (edge_w <= hi_w);
    base_ones = new_bit ? 3'd0 : ones_q;
    base_cnt  = new_bit ? 3'd0 : cnt_q;
    ones_d    = base_ones;
    cnt_d     = base_cnt;
    if (in_win) begin
      ones_d = RX_IN ? sat_inc(base_ones) : base_ones;
      cnt_d  = sat_inc(base_cnt);
    end
    // Only a window that collected every sample produces a decision; a
    // partial window after reset or re-enable is silently discarded.
    decide    = data_sample_en && in_win && (edge_w == hi_w) && (cnt_d == n_samples);
    // Requested vote wider than the prescale allows.
    cfg_err_d = (sample_mode && (prescale < 8)) || (prescale < 4);
  end

  // Configuration capture, accumulation and the registered vote outputs.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: every register here is small control state, so all are cleared by the async reset.
    if (!RST) begin
      cfg_prescale_q <= '0;
      cfg_mode_q     <= 1'b0;
      cfg_err        <= 1'b0;
      ones_q         <= 3'd0;
      cnt_q          <= 3'd0;
      sampled_bit    <= 1'b0;
      noise_err      <= 1'b0;
      sample_valid   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sample_valid <= 1'b0;
      if (!data_sample_en) begin
        cfg_prescale_q <= prescale;
        cfg_mode_q     <= sample_mode;
        cfg_err        <= cfg_err_d;
        ones_q         <= 3'd0;
        cnt_q          <= 3'd0;
      end else begin
        ones_q <= ones_d;
        cnt_q  <= cnt_d;
        if (decide) begin
          sampled_bit  <= ones_d > {1'b0, half_k};
          noise_err    <= (ones_d != 3'd0) && (ones_d != n_samples);
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule
